tick_timer: RTL



---
 rtl/tick_timer_pkg.sv | 11 +
 rtl/tick_timer.sv | 98 +++++++++
 2 files changed

// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick-enable consumer timers: state encoding and
// default counter width.
package tick_timer_pkg;

  localparam int unsigned DefCntWidth = 12;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_EXPIRE = 2'b10;

endpackage

// File: rtl/tick_timer.sv
// Programmable tick counter with one-shot / periodic modes, start/stop control,
// a single-cycle expiry pulse and a sticky expiry flag.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned         CntWidth    = DefCntWidth,
  parameter logic [CntWidth-1:0] ResetPeriod = '0
) (
  input  logic                CLK_IN,
  input  logic                RESET_N,
  input  logic                TICK_EN,
  input  logic                START,
  input  logic                STOP,
  input  logic                RELOAD_EN,
  input  logic [CntWidth-1:0] PERIOD,
  output logic                BUSY,
  output logic                DONE_O,
  output logic                EXPIRED,
  output logic [CntWidth-1:0] COUNT_O
);

  logic [1:0]          state, state_nxt;
  logic                reload_mode, reload_mode_nxt;
  logic                done, done_nxt;
  logic                expired, expired_nxt;
  logic [CntWidth-1:0] count, count_nxt;

  function automatic logic [CntWidth-1:0] sat_dec(input logic [CntWidth-1:0] v);
    return (v == '0) ? '0 : v - CntWidth'(1);
  endfunction

  always_comb begin
    state_nxt       = state;
    reload_mode_nxt = reload_mode;
    done_nxt        = 1'b0;
    expired_nxt     = expired;
    count_nxt       = count;

    if (STOP) begin
      state_nxt = ST_IDLE;
    end else if (START) begin
      // A restart discards any expiry that would have happened this cycle.
      reload_mode_nxt = RELOAD_EN;
      count_nxt       = PERIOD;
      expired_nxt     = 1'b0;
      state_nxt       = (PERIOD == '0) ? ST_EXPIRE : ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (TICK_EN) begin
            if (count <= CntWidth'(1)) begin
              done_nxt    = 1'b1;
              expired_nxt = 1'b1;
              // A zero period at reload would expire every cycle, so stop instead.
              if (reload_mode && (PERIOD != '0)) begin
                count_nxt = PERIOD;
              end else begin
                count_nxt = '0;
                state_nxt = ST_IDLE;
              end
            end else begin
              count_nxt = sat_dec(count);
            end
          end
        end
        ST_EXPIRE: begin
          done_nxt    = 1'b1;
          expired_nxt = 1'b1;
          count_nxt   = '0;
          state_nxt   = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      reload_mode <= 1'b0;
      done        <= 1'b0;
      expired     <= 1'b0;
      count       <= ResetPeriod;
    end else begin
      state       <= state_nxt;
      reload_mode <= reload_mode_nxt;
      done        <= done_nxt;
      expired     <= expired_nxt;
      count       <= count_nxt;
    end
  end

  assign BUSY    = (state == ST_RUN);
  assign DONE_O  = done;
  assign EXPIRED = expired;
  assign COUNT_O = count;

endmodule
